// File: rtl/async_fifo_pkg.sv
// Purpose : shared async FIFO types and helpers for the write- and read-side controllers.
// Contents: default geometry (WIDTH/DEPTH/ADDR), pointer width PTR_W, bin2gray, gray2bin.
// Usage   : import async_fifo_pkg::*; callers cast results down to their own pointer width.
package async_fifo_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int DEPTH_DEF = 8;
   localparam int ADDR_DEF  = 3;
   localparam int PTR_W     = ADDR_DEF + 1;

   // Both helpers work on a zero-extended 32-bit value, so any pointer width up to 32 can
   // share them; zero upper bits leave the result in the low bits unchanged.
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/async_fifo_wr_ctrl_if.sv
// Purpose : bundles the write-side FIFO signals: producer request, RAM write port, pointer exchange, status.
// Ports   : master = producer/read-domain side (drives push, push_data, rd_ptr_gray); slave = controller.
// Latency : pure wiring, no state.
interface async_fifo_wr_ctrl_if #(
   parameter int WIDTH = 16,
   parameter int ADDR  = 3
);
   logic             push;
   logic [WIDTH-1:0] push_data;
   logic [ADDR:0]    rd_ptr_gray;
   logic             we;
   logic [ADDR-1:0]  wr_addr;
   logic [WIDTH-1:0] data_in;
   logic [ADDR:0]    wr_ptr_gray;
   logic             full;
   logic             almost_full;
   logic             overflow;
   logic [ADDR:0]    wr_level;

   modport master (
      output push, push_data, rd_ptr_gray,
      input  we, wr_addr, data_in, wr_ptr_gray, full, almost_full, overflow, wr_level
   );

   modport slave (
      input  push, push_data, rd_ptr_gray,
      output we, wr_addr, data_in, wr_ptr_gray, full, almost_full, overflow, wr_level
   );
endinterface

// File: rtl/async_fifo_wr_ctrl_sync_2ff.sv
// Purpose : two-flop synchronizer for a Gray-coded pointer crossing into this clock domain.
// Ports   : clk, clr (async, active-high), d_i (foreign-domain bus), q_o (synchronized bus).
// Latency : 2 clk edges; no backpressure. Nothing combinational sits before the first flop.
module sync_2ff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] rq1_q;
   logic [W-1:0] rq2_q;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         rq1_q <= '0;
         rq2_q <= '0;
      end else begin
         rq1_q <= d_i;
         rq2_q <= rq1_q;
      end
   end

   assign q_o = rq2_q;

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Purpose : write-side controller of a dual-clock FIFO: RAM write port, Gray write pointer, full/level/overflow.
// Ports   : wr_clk, clr (async, active-high), bus (async_fifo_wr_ctrl_if.slave).
// Latency : we/wr_addr/data_in combinational; pointer, full, level registered on the accepting edge.
//           Push while full is dropped and latches sticky overflow. Macro ASYNC_FIFO_ALMOST_FULL_EN
//           enables the registered almost_full comparator; otherwise almost_full is tied low.
module async_fifo_wr_ctrl
   import async_fifo_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int ADDR     = ADDR_DEF,
   parameter int AF_LEVEL = 6
) (
   input  logic                 wr_clk,
   input  logic                 clr,
   async_fifo_wr_ctrl_if.slave  bus
);

   localparam int PW = ADDR + 1;

   if (DEPTH != (1 << ADDR)) begin : g_depth_chk
      $error("async_fifo_wr_ctrl: DEPTH must equal 2**ADDR");
   end
   if (AF_LEVEL > DEPTH) begin : g_af_chk
      $error("async_fifo_wr_ctrl: AF_LEVEL must not exceed DEPTH");
   end

   logic [PW-1:0]    wr_bin_q, wr_bin_d;
   logic [PW-1:0]    wr_ptr_gray_q, wr_gray_d;
   logic [PW-1:0]    wr_level_q, wr_level_d;
   logic [PW-1:0]    rq2;
   logic [PW-1:0]    rd_bin;
   logic [PW-1:0]    full_cmp;
   logic             full_q, full_d;
   logic             overflow_q, overflow_d;
   logic             we;
   logic [WIDTH-1:0] push_dat;

   sync_2ff #(.W(PW)) u_rd_sync (
      .clk (wr_clk),
      .clr (clr),
      .d_i (bus.rd_ptr_gray),
      .q_o (rq2)
   );

   // clr gates the enable so the RAM cannot be written while the pointers are held at zero.
   assign we         = bus.push & ~full_q & ~clr;
   assign wr_bin_d   = wr_bin_q + PW'(we);
   assign wr_gray_d  = PW'(bin2gray(32'(wr_bin_d)));
   assign rd_bin     = PW'(gray2bin(32'(rq2)));

   // Full when the write pointer is exactly one lap ahead: in Gray code that is the read
   // pointer with its two MSBs inverted. Using wr_bin_d makes the filling write assert full.
   assign full_cmp   = {~rq2[ADDR:ADDR-1], rq2[ADDR-2:0]};
   assign full_d     = (wr_gray_d == full_cmp);
   assign wr_level_d = wr_bin_d - rd_bin;
   assign overflow_d = overflow_q | (bus.push & full_q);

   always_ff @(posedge wr_clk or posedge clr) begin
      if (clr) begin
         wr_bin_q      <= '0;
         wr_ptr_gray_q <= '0;
         wr_level_q    <= '0;
         full_q        <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         wr_bin_q      <= wr_bin_d;
         wr_ptr_gray_q <= wr_gray_d;
         wr_level_q    <= wr_level_d;
         full_q        <= full_d;
         overflow_q    <= overflow_d;
      end
   end

`ifdef ASYNC_FIFO_ALMOST_FULL_EN
   logic almost_full_q;

   always_ff @(posedge wr_clk or posedge clr) begin
      if (clr) begin
         almost_full_q <= 1'b0;
      end else begin
         almost_full_q <= (32'(wr_level_d) >= AF_LEVEL);
      end
   end

   assign bus.almost_full = almost_full_q;
`else
   assign bus.almost_full = 1'b0;
`endif

   assign push_dat        = bus.push_data;
   assign bus.data_in     = push_dat;
   assign bus.we          = we;
   assign bus.wr_addr     = wr_bin_q[ADDR-1:0];
   assign bus.wr_ptr_gray = wr_ptr_gray_q;
   assign bus.full        = full_q;
   assign bus.wr_level    = wr_level_q;
   assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Purpose : self-checking bench for async_fifo_wr_ctrl (WIDTH=16, DEPTH=8, ADDR=3, AF_LEVEL=6).
// Ports   : none; drives the interface master side and a free-running wr_clk.
// Flow    : reset, fill table, overflow, drain release, wrap; expectations queued and popped per edge.
module tb_async_fifo_wr_ctrl;

   logic wr_clk;
   logic clr;

   async_fifo_wr_ctrl_if #(.WIDTH(16), .ADDR(3)) bus ();

   async_fifo_wr_ctrl #(
      .WIDTH(16), .DEPTH(8), .ADDR(3), .AF_LEVEL(6)
   ) dut (
      .wr_clk (wr_clk),
      .clr    (clr),
      .bus    (bus)
   );

`ifdef ASYNC_FIFO_ALMOST_FULL_EN
   localparam bit AF_EN = 1'b1;
`else
   localparam bit AF_EN = 1'b0;
`endif

   typedef struct {
      logic [15:0] dat;
      logic [2:0]  addr;
      logic        full;
      logic [3:0]  lvl;
      logic [3:0]  gray;
      logic        af;
   } vec_t;

   typedef struct {
      logic [3:0] gray;
      logic       full;
      logic [3:0] lvl;
      logic       af;
   } exp_t;

   vec_t tbl[8];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   initial begin
      wr_clk = 1'b0;
      forever #5 wr_clk = ~wr_clk;
   end

   initial begin
      #50000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge wr_clk);
      #1;
   endtask

   function automatic logic [3:0] g4(input logic [3:0] b);
      return b ^ {1'b0, b[3:1]};
   endfunction

   // Pops the oldest queued expectation and compares the registered outputs against it.
   task automatic check_sb(input string nm);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard empty act=0 exp=1", nm);
      end else begin
         checks--;
         e = sb.pop_front();
         chk({nm, "_gray"}, 32'(bus.wr_ptr_gray), 32'(e.gray));
         chk({nm, "_full"}, 32'(bus.full), 32'(e.full));
         chk({nm, "_lvl"},  32'(bus.wr_level), 32'(e.lvl));
         chk({nm, "_af"},   32'(bus.almost_full), 32'(e.af));
      end
   endtask

   task automatic check_all_zero(input string nm);
      chk({nm, "_we"},   32'(bus.we), 0);
      chk({nm, "_addr"}, 32'(bus.wr_addr), 0);
      chk({nm, "_gray"}, 32'(bus.wr_ptr_gray), 0);
      chk({nm, "_full"}, 32'(bus.full), 0);
      chk({nm, "_lvl"},  32'(bus.wr_level), 0);
      chk({nm, "_ovf"},  32'(bus.overflow), 0);
      chk({nm, "_af"},   32'(bus.almost_full), 0);
   endtask

   initial begin
      logic [3:0] gray_lit [8];
      logic [3:0] bin_m;
      logic [3:0] prev_g;
      exp_t       e;

      gray_lit = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
      for (int i = 0; i < 8; i++) begin
         tbl[i].dat  = 16'(i + 1);
         tbl[i].addr = 3'(i);
         tbl[i].full = (i == 7);
         tbl[i].lvl  = 4'(i + 1);
         tbl[i].gray = gray_lit[i];
         tbl[i].af   = AF_EN && (i + 1 >= 6);
      end

      // ---- reset, then clr mid-stream after 3 pushes ----
      clr = 1'b1;
      bus.push = 1'b0;
      bus.push_data = '0;
      bus.rd_ptr_gray = '0;
      tick();
      tick();
      check_all_zero("rst");
      clr = 1'b0;
      bus.push = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.push_data = 16'h00A0 + 16'(i);
         tick();
      end
      chk("pre_clr_gray", 32'(bus.wr_ptr_gray), 32'(4'b0010));
      chk("pre_clr_lvl",  32'(bus.wr_level), 3);
      #3;
      clr = 1'b1;
      #1;
      check_all_zero("mid_clr");
      bus.push = 1'b0;
      tick();
      clr = 1'b0;
      #1;
      chk("rel_addr", 32'(bus.wr_addr), 0);

      // ---- fill: table-driven, read pointer held at 0 ----
      for (int i = 0; i < 8; i++) begin
         bus.push = 1'b1;
         bus.push_data = tbl[i].dat;
         #1;
         chk("fill_we",   32'(bus.we), 1);
         chk("fill_addr", 32'(bus.wr_addr), 32'(tbl[i].addr));
         chk("fill_din",  32'(bus.data_in), 32'(tbl[i].dat));
         e.gray = tbl[i].gray;
         e.full = tbl[i].full;
         e.lvl  = tbl[i].lvl;
         e.af   = tbl[i].af;
         sb.push_back(e);
         @(posedge wr_clk);
         #1;
         check_sb("fill");
      end

      // ---- overflow: push while full is dropped, flag sticks ----
      bus.push = 1'b1;
      bus.push_data = 16'h0009;
      #1;
      chk("ovf_we",   32'(bus.we), 0);
      chk("ovf_addr", 32'(bus.wr_addr), 0);
      tick();
      bus.push = 1'b0;
      chk("ovf_flag", 32'(bus.overflow), 1);
      chk("ovf_gray", 32'(bus.wr_ptr_gray), 32'(4'b1100));
      chk("ovf_full", 32'(bus.full), 1);
      chk("ovf_lvl",  32'(bus.wr_level), 8);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("ovf_sticky", 32'(bus.overflow), 1);
      end

      // ---- drain release: reader frees one slot ----
      // Edge 1 lands it in rq1, edge 2 in rq2, and the registered full/level follow on edge 3.
      bus.rd_ptr_gray = 4'b0001;
      tick();
      chk("drain_full_e1", 32'(bus.full), 1);
      tick();
      tick();
      chk("drain_full", 32'(bus.full), 0);
      chk("drain_lvl",  32'(bus.wr_level), 7);
      bus.push = 1'b1;
      bus.push_data = 16'h0010;
      #1;
      chk("drain_we",   32'(bus.we), 1);
      chk("drain_addr", 32'(bus.wr_addr), 0);
      tick();
      bus.push = 1'b0;
      chk("drain_refull", 32'(bus.full), 1);

      // ---- wrap: 20 pushes, read pointer trailing the writer ----
      clr = 1'b1;
      bus.rd_ptr_gray = '0;
      tick();
      clr = 1'b0;
      chk("wrap_ovf_clr", 32'(bus.overflow), 0);
      bin_m = '0;
      for (int k = 0; k < 20; k++) begin
         bus.push = 1'b1;
         bus.push_data = 16'h1000 + 16'(k);
         #1;
         chk("wrap_we",   32'(bus.we), 1);
         chk("wrap_addr", 32'(bus.wr_addr), 32'(bin_m[2:0]));
         prev_g = bus.wr_ptr_gray;
         @(posedge wr_clk);
         #1;
         bus.push = 1'b0;
         bin_m = bin_m + 4'd1;
         chk("wrap_gray", 32'(bus.wr_ptr_gray), 32'(g4(bin_m)));
         chk("wrap_1bit", 32'($countones(prev_g ^ bus.wr_ptr_gray)), 1);
         chk("wrap_nofull", 32'(bus.full), 0);
         if (k == 15) begin
            chk("wrap_to0", 32'(bus.wr_ptr_gray), 0);
         end
         bus.rd_ptr_gray = g4(bin_m);
      end
      tick();
      tick();
      tick();
      chk("wrap_lvl_end", 32'(bus.wr_level), 0);
      chk("wrap_sb_empty", 32'(sb.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
